// File: rtl/irq_pending_ctrl_if.sv
// Request/grant bundle for irq_pending_ctrl: request and mask lines in, pending flags and granted index out.
// master = the pending controller, slave = the requester/consumer side.
interface irq_pending_ctrl_if #(
  parameter int N = 8,
  parameter int W = 3
);
  logic [N-1:0] req;
  logic [N-1:0] mask;
  logic [N-1:0] pend;
  logic [W-1:0] idx;
  logic         valid;
  logic         ready;

  modport master (
    input  req, mask, ready,
    output pend, idx, valid
  );

  modport slave (
    output req, mask, ready,
    input  pend, idx, valid
  );
endinterface

// File: rtl/irq_pending_ctrl.sv
// Pending-request collector with masked fixed-priority selection (bit N-1 highest); optional IRQ_EDGE_DETECT_EN sets on rising edges.
// Latency: req -> pend 1 cycle, req -> valid 2 cycles; at most one grant every 2 cycles.
// Backpressure: the granted idx stays frozen while ready=0; valid only drops on transfer or reset.
module irq_pending_ctrl #(
  parameter int N = 8,
  parameter int W = 3
) (
  input logic              clk,
  input logic              rst_n,
  irq_pending_ctrl_if.master irq
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  logic [0:0]   state_q;
  logic [N-1:0] pend_q;
  logic [W-1:0] idx_q;
  logic [N-1:0] set;
  logic [N-1:0] clr;
  logic [N-1:0] elig;
  logic [W-1:0] sel;
  logic         xfer;

`ifdef IRQ_EDGE_DETECT_EN
  logic [N-1:0] req_q;

  always_ff @(posedge clk) begin
    if (!rst_n) req_q <= '0;
    else        req_q <= irq.req;
  end

  assign set = irq.req & ~req_q;
`else
  assign set = irq.req;
`endif

  assign xfer = (state_q == ST_PRESENT) && irq.ready;
  assign elig = pend_q & irq.mask;

  always_comb begin
    clr = '0;
    if (xfer) clr[idx_q] = 1'b1;
  end

  // Ascending scan so the highest eligible line is the last one written.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (elig[i]) sel = W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q  <= '0;
      idx_q   <= '0;
      state_q <= ST_IDLE;
    end else begin
      pend_q <= (pend_q & ~clr) | set;
      case (state_q)
        ST_IDLE: begin
          if (|elig) begin
            idx_q   <= sel;
            state_q <= ST_PRESENT;
          end
        end
        default: begin
          if (irq.ready) state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign irq.pend  = pend_q;
  assign irq.idx   = idx_q;
  assign irq.valid = (state_q == ST_PRESENT);

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed plus randomized bench for irq_pending_ctrl against a cycle-level behavioural model.
module tb_irq_pending_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  irq_pending_ctrl_if #(.N(8), .W(3)) bus ();

  irq_pending_ctrl #(.N(8), .W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .irq   (bus)
  );

  always #5 clk = ~clk;

  // Reference state: what the consumer should observe after each edge.
  bit [7:0] m_pend;
  bit [7:0] m_req_hist;
  bit       m_valid;
  bit [2:0] m_idx;

  function automatic int top_bit(bit [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_edge();
    bit [7:0] newreq;
    bit [7:0] p;
    int       t;
    if (!rst_n) begin
      m_pend = '0; m_valid = 1'b0; m_idx = '0; m_req_hist = '0;
    end else begin
`ifdef IRQ_EDGE_DETECT_EN
      newreq = bus.req & ~m_req_hist;
`else
      newreq = bus.req;
`endif
      p = m_pend;
      if (m_valid) begin
        if (bus.ready) begin
          p[m_idx] = 1'b0;
          m_valid  = 1'b0;
        end
      end else begin
        t = top_bit(m_pend & bus.mask);
        if (t >= 0) begin
          m_idx   = 3'(t);
          m_valid = 1'b1;
        end
      end
      m_pend     = p | newreq;
      m_req_hist = bus.req;
    end
  endtask

  task automatic check(string tag, int obs, int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cycle(string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, ".pend"},  int'(bus.pend),  int'(m_pend));
    check({tag, ".valid"}, int'(bus.valid), int'(m_valid));
    check({tag, ".idx"},   int'(bus.idx),   int'(m_idx));
  endtask

  task automatic drain(string tag);
    bus.req = '0; bus.mask = 8'hFF; bus.ready = 1'b1;
    for (int i = 0; i < 20; i++) cycle(tag);
  endtask

  int grants;

  initial begin
    bus.req = 8'hFF; bus.mask = 8'hFF; bus.ready = 1'b0;
    m_pend = '0; m_req_hist = '0; m_valid = 1'b0; m_idx = '0;

    // Reset held with all requests asserted
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle("rst");
      check("rst.pend0", int'(bus.pend), 0);
      check("rst.valid0", int'(bus.valid), 0);
      check("rst.idx0", int'(bus.idx), 0);
    end
    rst_n = 1'b1;
    cycle("rel1");
    check("rel1.pend", int'(bus.pend), 8'hFF);
    check("rel1.valid", int'(bus.valid), 0);
    bus.req = '0;
    cycle("rel2");
    check("rel2.valid", int'(bus.valid), 1);
    check("rel2.idx", int'(bus.idx), 7);
    drain("rel_drain");

    // Priority order 5, 2, 0 with one idle cycle between grants
    begin
      bit exp_v[7] = '{0, 1, 0, 1, 0, 1, 0};
      int exp_i[7] = '{0, 5, 5, 2, 2, 0, 0};
      bus.mask = 8'hFF; bus.ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
        bus.req = (i == 0) ? 8'b0010_0101 : 8'h00;
        cycle("prio");
        check($sformatf("prio.v%0d", i), int'(bus.valid), int'(exp_v[i]));
        if (exp_v[i]) check($sformatf("prio.i%0d", i), int'(bus.idx), exp_i[i]);
      end
      check("prio.pend_end", int'(bus.pend), 0);
    end

    // Backpressure: grant of line 1 stays frozen when line 7 arrives
    bus.ready = 1'b0; bus.req = 8'b0000_0010;
    cycle("bp");
    bus.req = '0;
    cycle("bp");
    bus.req = 8'h80;
    cycle("bp");
    bus.req = '0;
    for (int i = 0; i < 3; i++) begin
      cycle("bp_hold");
      check("bp.idx_hold", int'(bus.idx), 1);
      check("bp.valid_hold", int'(bus.valid), 1);
    end
    bus.ready = 1'b1;
    cycle("bp_acc");
    check("bp.acc_valid", int'(bus.valid), 0);
    check("bp.acc_pend", int'(bus.pend), 8'h80);
    cycle("bp_next");
    check("bp.next_idx", int'(bus.idx), 7);
    check("bp.next_valid", int'(bus.valid), 1);
    drain("bp_drain");

    // Masking: line 7 waits until unmasked
    bus.mask = 8'h7F; bus.ready = 1'b1; bus.req = 8'b1000_0001;
    cycle("msk");
    bus.req = '0;
    cycle("msk");
    check("msk.idx0", int'(bus.idx), 0);
    check("msk.valid0", int'(bus.valid), 1);
    for (int i = 0; i < 3; i++) begin
      cycle("msk_wait");
      check("msk.wait_valid", int'(bus.valid), 0);
      check("msk.wait_pend", int'(bus.pend), 8'h80);
    end
    bus.mask = 8'hFF;
    cycle("msk_un");
    check("msk.un_valid", int'(bus.valid), 1);
    check("msk.un_idx", int'(bus.idx), 7);
    drain("msk_drain");

`ifdef IRQ_EDGE_DETECT_EN
    // Held line grants once; a one-cycle low re-arms it
    bus.ready = 1'b1; bus.req = 8'h08; grants = 0;
    for (int i = 0; i < 10; i++) begin
      cycle("edge_a");
      if (bus.valid) grants++;
    end
    for (int i = 0; i < 4; i++) begin
      cycle("edge_a");
      if (bus.valid) grants++;
    end
    check("edge.first_grants", grants, 1);
    bus.req = '0;
    cycle("edge_low");
    bus.req = 8'h08; grants = 0;
    for (int i = 0; i < 10; i++) begin
      cycle("edge_b");
      if (bus.valid) begin
        grants++;
        check("edge.idx", int'(bus.idx), 3);
      end
    end
    check("edge.second_grants", grants, 1);
`else
    // Held level request survives its own accept and is granted again
    bus.ready = 1'b1; bus.req = 8'h10;
    cycle("coll");
    cycle("coll");
    check("coll.grant1", int'(bus.idx), 4);
    cycle("coll_acc");
    check("coll.pend_kept", int'(bus.pend[4]), 1);
    check("coll.acc_valid", int'(bus.valid), 0);
    cycle("coll");
    check("coll.grant2_valid", int'(bus.valid), 1);
    check("coll.grant2_idx", int'(bus.idx), 4);
`endif
    drain("dir_drain");

    // Randomized traffic including occasional reset during a grant
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      bus.req   = 8'($urandom) & 8'($urandom);
      bus.mask  = 8'($urandom) | 8'($urandom);
      bus.ready = ($urandom_range(0, 2) != 0);
      cycle("rand");
    end
    rst_n = 1'b1;
    drain("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/irq_pending_ctrl.md
# irq_pending_ctrl

Registered request-collection stage that sits directly upstream of the 8-to-3 priority encoder path. It latches up to eight request lines into pending flags, applies a mask, and selects the highest-priority pending line. Bit 7 has the highest priority and bit 0 the lowest, the same order the encoder uses. The selected index is presented with a valid/ready handshake, and the serviced pending bit is cleared on acceptance.

## Interface
- `N`, 8: number of request lines. Fixed at 8 in this revision.
- `W`, 3: index width. Must satisfy 2^W >= N.

- `clk`  in  1  Single clock. All state updates on the rising edge.
- `rst_n`  in  1  Reset. Synchronous, active-low.
- `req`  in  N  Request lines. Asynchronous to the consumer but already synchronised to `clk`.
- `mask`  in  N  Per-line enable. 1 means eligible for selection. Masked lines still accumulate pending state.
- `pend`  out  N  Pending flags, registered.
- `idx`  out  W  Selected line index. Stable while `valid`=1.
- `valid`  out  1  `idx` is valid.
- `ready`  in  1  Consumer accepts `idx`. A transfer occurs when `valid`&&`ready`.

## Operation
**Reset**
- On `clk` edge with `rst_n`=0: `pend`=0, `valid`=0, `idx`=0, state=IDLE.
- Under `IRQ_EDGE_DETECT_EN`, the edge history register is also cleared to 0.

**Pending update (every cycle, `rst_n`=1)**
- `pend_next = (pend & ~clr) | set`.
- `set` is `req` in level mode, or rising edges of `req` in edge mode.
- `clr` is the one-hot decode of `idx` on a transfer cycle, otherwise 0.
- Set wins over clear on the same bit in the same cycle.

**Eligibility**
- `elig = pend & mask`, using the registered `pend`.
- Selection picks the highest set bit of `elig`.

**State machine**
- **IDLE:** `valid`=0.
  - If `elig`≠0: load `idx` with the highest set bit of `elig`, set `valid`=1, go to PRESENT.
  - Else stay in IDLE; `idx` holds its last value.
- **PRESENT:** `valid`=1; `idx` is frozen.
  - Changes to `mask` or `pend` never retract or alter `idx`, even if a higher-priority line arrives.
  - On `ready`=1: clear `pend[idx]` per the update rule, set `valid`=0, go to IDLE.
  - On `ready`=0: hold.

**Boundary conditions**
- All pending bits masked: `valid` stays 0 and `pend` keeps accumulating.
- Unmasking a pending line in IDLE makes `valid` rise on the next edge.
- Line 0 is a real index: `idx`=0 with `valid`=1 is legal. There is no "none" encoding; `valid`=0 means none.
- A `req` bit held high in level mode re-sets its pending bit on the accept cycle, so the line stays pending.
- Reset asserted during PRESENT drops the outstanding grant with no transfer.

## Timing
- Request to `pend`: `req` sampled at edge t gives `pend` bit = 1 after edge t.
- Request to grant: `valid`=1 after edge t+1 when idle and eligible (2-cycle latency).
- Accept: transfer at edge a gives `valid`=0 and the `pend` bit cleared after edge a.
- Throughput: the earliest next `valid` is after edge a+1, so at most one grant per 2 cycles.
- `valid` never drops without a transfer, except through reset.

## Configuration
- `IRQ_EDGE_DETECT_EN` defined:
  - Adds an N-bit `req_q` register, with `set = req & ~req_q`.
  - A line held high sets pending once and only sets again after going low for at least 1 cycle.
  - Because `req_q` resets to 0, a `req` that is high when reset is released produces one set.
- `IRQ_EDGE_DETECT_EN` undefined: level mode, `set = req`, and there is no `req_q`.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with `req`=8'hFF, `mask`=8'hFF.
  - Required: `pend`=0, `valid`=0, `idx`=0 throughout.
  - After release, `valid`=1 with `idx`=3'b111 two edges later.
- **Priority order:** pulse `req`=8'b0010_0101 for 1 cycle, `mask`=8'hFF, `ready`=1.
  - Required grants in order: `idx`=5, then 2, then 0, each `valid` pulse 1 cycle wide, separated by 1 idle cycle.
  - `pend`=0 after the third grant.
- **Backpressure:** `ready`=0 with `pend`=8'b0000_0010, then raise `req[7]`.
  - Required: `idx` stays 1 and `valid` stays 1.
  - After `ready`=1, the next grant is `idx`=7.
- **Masking:** `req` pulse 8'b1000_0001, `mask`=8'b0111_1111.
  - Required: grant `idx`=0 only.
  - `pend`=8'b1000_0000 remains.
  - Setting `mask[7]`=1 gives `valid`=1 with `idx`=7 one edge later.
- **Set/clear collision:** level mode, `req[4]` held high through the accept of `idx`=4.
  - Required: `pend[4]` remains 1 and `idx`=4 is granted again 2 cycles later.
- **Edge mode (with `IRQ_EDGE_DETECT_EN`):** `req[3]` held high for 10 cycles.
  - Required: exactly one grant of `idx`=3.
  - Drop `req[3]` for 1 cycle then raise it: exactly one more grant.
